fifo_rx_credit: RTL and testbench

// - Receive-side buffer of the SpaceWire link: stores N-Chars (data/EOP/EEP) from the character decoder and feeds the host.
// - Owns receiver flow-control credit: requests one FCT from the transmitter for every 8 free slots, at most 56 credit outstanding.
// - Detects credit violations (char arriving with zero credit) per ECSS-E-ST-50-12C.

---
 rtl/fifo_rx_credit.sv | 99 +++++++++
 tb/tb_fifo_rx_credit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rx_credit.sv
// fifo_rx_credit: SpaceWire receive FIFO with FCT credit generation and credit-violation detection.
// Optional FIFO_RX_PKT_COUNT_EN adds pkt_count, the number of stored EOP/EEP markers.
module fifo_rx_credit #(
   parameter int DWIDTH     = 9,
   parameter int AWIDTH     = 6,
   parameter int MAX_CREDIT = 56
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              link_run,
   input  logic              rx_valid,
   input  logic [DWIDTH-1:0] rx_data,
   input  logic              rd_en,
   output logic [DWIDTH-1:0] data_out,
   output logic              data_valid,
   output logic              f_full,
   output logic              f_empty,
   output logic [AWIDTH:0]   counter,
   output logic              fct_req,
   input  logic              fct_ack,
   output logic [5:0]        credit,
   output logic              credit_error
`ifdef FIFO_RX_PKT_COUNT_EN
   ,
   output logic [AWIDTH:0]   pkt_count
`endif
);
   localparam int DEPTH = 2**AWIDTH;
   localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH+1)'(DEPTH);

   typedef enum logic {IDLE, REQ} state_t;

   logic [DWIDTH-1:0] mem [DEPTH];
   logic [AWIDTH-1:0] wr_ptr, rd_ptr;
   logic [AWIDTH:0]   free, cnt_next;
   logic [5:0]        credit_next;
   logic              wr_ok, rd_ok, ack_ok;
   state_t            state, state_next;

   assign wr_ok       = rx_valid & link_run & (credit != '0) & ~f_full;
   assign rd_ok       = rd_en & ~f_empty;
   assign ack_ok      = link_run & fct_ack & (state == REQ);
   assign free        = DEPTH_W - counter;
   assign cnt_next    = counter + (AWIDTH+1)'(wr_ok) - (AWIDTH+1)'(rd_ok);
   // A write and an FCT in the same cycle net +7 credit.
   assign credit_next = link_run ? credit - 6'(wr_ok) + (ack_ok ? 6'd8 : 6'd0) : '0;
   assign fct_req     = (state == REQ);

   always_comb begin
      state_next = state;
      if (!link_run)
         state_next = IDLE;
      else if (state == REQ)
         state_next = fct_ack ? IDLE : REQ;
      else if ((free - (AWIDTH+1)'(credit)) >= (AWIDTH+1)'(8) && credit <= 6'(MAX_CREDIT - 8))
         state_next = REQ;
   end

   always_ff @(posedge clock)
      if (wr_ok) mem[wr_ptr] <= rx_data;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         data_out     <= '0;
         data_valid   <= 1'b0;
         counter      <= '0;
         f_full       <= 1'b0;
         f_empty      <= 1'b1;
         credit       <= '0;
         credit_error <= 1'b0;
         state        <= IDLE;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + AWIDTH'(1);
         if (rd_ok) begin
            rd_ptr   <= rd_ptr + AWIDTH'(1);
            data_out <= mem[rd_ptr];
         end
         data_valid   <= rd_ok;
         counter      <= cnt_next;
         f_full       <= (cnt_next == DEPTH_W);
         f_empty      <= (cnt_next == '0);
         credit       <= credit_next;
         credit_error <= rx_valid & link_run & ~wr_ok;
         state        <= state_next;
      end
   end

`ifdef FIFO_RX_PKT_COUNT_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         pkt_count <= '0;
      else
         pkt_count <= pkt_count + (AWIDTH+1)'(wr_ok & rx_data[DWIDTH-1])
                                - (AWIDTH+1)'(rd_ok & mem[rd_ptr][DWIDTH-1]);
   end
`endif
endmodule

// File: tb/tb_fifo_rx_credit.sv
// tb_fifo_rx_credit: randomized self-checking bench against a queue-based credit model.
// Define FIFO_RX_PKT_COUNT_EN to also exercise pkt_count.
module tb_fifo_rx_credit;
   logic       clock = 1'b0, reset, link_run, rx_valid, rd_en, fct_ack;
   logic [8:0] rx_data, data_out;
   logic       data_valid, f_full, f_empty, fct_req, credit_error;
   logic [6:0] counter;
   logic [5:0] credit;
`ifdef FIFO_RX_PKT_COUNT_EN
   logic [6:0] pkt_count;
`endif

   int errors = 0, checks = 0;
   int q[$];
   int m_credit, m_dout, wr_cnt;
   bit m_req, m_dv, m_err;

   always #5 clock = ~clock;

   fifo_rx_credit dut (
      .clock(clock), .reset(reset), .link_run(link_run), .rx_valid(rx_valid),
      .rx_data(rx_data), .rd_en(rd_en), .data_out(data_out), .data_valid(data_valid),
      .f_full(f_full), .f_empty(f_empty), .counter(counter), .fct_req(fct_req),
      .fct_ack(fct_ack), .credit(credit), .credit_error(credit_error)
`ifdef FIFO_RX_PKT_COUNT_EN
      , .pkt_count(pkt_count)
`endif
   );

   // Advance one clock and update the model from the inputs seen at that edge.
   task automatic tick();
      int  oc, free;
      bit  oreq, wr, rdok;
      @(posedge clock);
      oc   = m_credit;
      oreq = m_req;
      free = 64 - q.size();
      wr   = rx_valid && link_run && oc > 0 && q.size() < 64;
      m_err = rx_valid && link_run && !wr;
      rdok = rd_en && q.size() > 0;
      m_dv = rdok;
      if (rdok) m_dout = q.pop_front();
      if (!link_run) begin
         m_credit = 0;
         m_req    = 0;
      end else begin
         m_credit = oc - int'(wr) + ((oreq && fct_ack) ? 8 : 0);
         m_req    = oreq ? !fct_ack : (free - oc >= 8 && oc <= 48);
      end
      if (wr) begin
         q.push_back(int'(rx_data));
         wr_cnt++;
      end
      #1;
   endtask

   function automatic int markers();
      int n = 0;
      foreach (q[i]) if (q[i][8]) n++;
      return n;
   endfunction

   task automatic test_reset();
      reset = 1'b1; link_run = 0; rx_valid = 0; rd_en = 0; fct_ack = 0; rx_data = '0;
      q.delete(); m_credit = 0; m_req = 0; m_dv = 0; m_err = 0; m_dout = 0; wr_cnt = 0;
      #12;
      checks++;
      if (f_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", f_empty); end
      checks++;
      if ({data_out, data_valid, f_full, counter, fct_req, credit, credit_error} !== 26'd0) begin
         errors++;
         $display("FAIL reset_outputs: got dout=%0h dv=%b full=%b cnt=%0d req=%b cr=%0d err=%b want all 0",
                  data_out, data_valid, f_full, counter, fct_req, credit, credit_error);
      end
      reset = 1'b0;
      tick();
      checks++;
      if (fct_req !== 1'b0 || credit !== 6'd0) begin
         errors++; $display("FAIL idle_no_link: got req=%b cr=%0d want 0 0", fct_req, credit);
      end
   endtask

   task automatic test_credit_init();
      int acks = 0, wait_c = 0;
      link_run = 1'b1;
      for (int i = 0; i < 120; i++) begin
         fct_ack = m_req && wait_c == 2;
         if (fct_ack) begin acks++; wait_c = 0; end
         tick();
         if (m_req) wait_c++;
         checks++;
         if (fct_req !== m_req || credit !== 6'(m_credit)) begin
            errors++;
            $display("FAIL init_cycle%0d: got req=%b cr=%0d want req=%b cr=%0d", i, fct_req, credit, m_req, m_credit);
         end
      end
      fct_ack = 0;
      checks++;
      if (credit !== 6'd56 || fct_req !== 1'b0) begin
         errors++; $display("FAIL init_final: got cr=%0d req=%b want 56 0", credit, fct_req);
      end
      checks++;
      if (acks != 7) begin errors++; $display("FAIL init_fct_count: got %0d want 7", acks); end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 56; i++) begin
         rx_data = 9'(i); rx_valid = 1;
         tick();
         checks++;
         if (counter !== 7'(i + 1) || credit !== 6'(m_credit) || fct_req !== m_req) begin
            errors++;
            $display("FAIL fill%0d: got cnt=%0d cr=%0d req=%b want %0d %0d %b", i, counter, credit, fct_req, i + 1, m_credit, m_req);
         end
      end
      rx_valid = 0;
      checks++;
      if (counter !== 7'd56 || credit !== 6'd0 || fct_req !== 1'b1 || f_full !== 1'b0) begin
         errors++;
         $display("FAIL fill_end: got cnt=%0d cr=%0d req=%b full=%b want 56 0 1 0", counter, credit, fct_req, f_full);
      end
      rx_data = 9'h038; rx_valid = 1;
      tick();
      rx_valid = 0;
      checks++;
      if (credit_error !== 1'b1 || counter !== 7'd56) begin
         errors++; $display("FAIL credit_violation: got err=%b cnt=%0d want 1 56", credit_error, counter);
      end
      tick();
      checks++;
      if (credit_error !== 1'b0) begin errors++; $display("FAIL err_pulse: got %b want 0", credit_error); end
   endtask

   task automatic test_read8();
      for (int i = 0; i < 8; i++) begin
         rd_en = 1;
         tick();
         checks++;
         if (data_valid !== 1'b1 || data_out !== 9'(i)) begin
            errors++; $display("FAIL read%0d: got dv=%b data=%0h want 1 %0h", i, data_valid, data_out, i);
         end
      end
      rd_en = 0;
      tick();
      checks++;
      if (data_valid !== 1'b0 || data_out !== 9'h007 || counter !== 7'd48) begin
         errors++; $display("FAIL read_end: got dv=%b data=%0h cnt=%0d want 0 7 48", data_valid, data_out, counter);
      end
   endtask

   task automatic test_simultaneous();
      int pre, n;
      rd_en = 1;
      repeat (38) tick();
      rd_en = 0;
      fct_ack = 1;
      tick();
      fct_ack = 0;
      checks++;
      if (credit !== 6'd8 || counter !== 7'd10) begin
         errors++; $display("FAIL ack_credit: got cr=%0d cnt=%0d want 8 10", credit, counter);
      end
      n = 0;
      while (!m_req && n < 10) begin tick(); n++; end
      checks++;
      if (fct_req !== 1'b1) begin errors++; $display("FAIL req_rearm: got %b want 1", fct_req); end
      pre = m_credit;
      rx_valid = 1; rx_data = 9'h0AA; rd_en = 1; fct_ack = 1;
      tick();
      rx_valid = 0; rd_en = 0; fct_ack = 0;
      checks++;
      if (counter !== 7'd10 || credit !== 6'(pre + 7) || data_out !== 9'h02E || data_valid !== 1'b1) begin
         errors++;
         $display("FAIL simultaneous: got cnt=%0d cr=%0d data=%0h dv=%b want 10 %0d 2e 1", counter, credit, data_out, data_valid, pre + 7);
      end
   endtask

   task automatic test_link_drop();
      int n = 0;
      while (!m_req && n < 10) begin tick(); n++; end
      checks++;
      if (fct_req !== 1'b1) begin errors++; $display("FAIL drop_pre_req: got %b want 1", fct_req); end
      link_run = 0;
      tick();
      checks++;
      if (fct_req !== 1'b0 || credit !== 6'd0 || counter !== 7'd10) begin
         errors++; $display("FAIL link_drop: got req=%b cr=%0d cnt=%0d want 0 0 10", fct_req, credit, counter);
      end
      rx_valid = 1; rx_data = 9'h055;
      tick();
      tick();
      rx_valid = 0;
      checks++;
      if (credit_error !== 1'b0 || counter !== 7'd10) begin
         errors++; $display("FAIL rx_while_down: got err=%b cnt=%0d want 0 10", credit_error, counter);
      end
      link_run = 1;
   endtask

   task automatic test_stream();
      int r, n, start = wr_cnt;
      for (int i = 0; i < 6000 && wr_cnt - start < 200; i++) begin
         r = $urandom_range(0, 15);
         rx_data  = (r == 0) ? 9'h100 : (r == 1) ? 9'h101 : {1'b0, 8'($urandom)};
         rx_valid = $urandom_range(0, 1) == 1;
         rd_en    = $urandom_range(0, 2) != 0;
         fct_ack  = $urandom_range(0, 2) == 0;
         tick();
         checks++;
         if (data_valid !== m_dv || (m_dv && data_out !== 9'(m_dout)) || counter !== 7'(q.size())
             || credit !== 6'(m_credit) || fct_req !== m_req || credit_error !== m_err
             || f_empty !== (q.size() == 0) || f_full !== (q.size() == 64) || int'(credit) > 64 - int'(counter)) begin
            errors++;
            $display("FAIL stream%0d: got dv=%b d=%0h cnt=%0d cr=%0d req=%b err=%b want dv=%b d=%0h cnt=%0d cr=%0d req=%b err=%b",
                     i, data_valid, data_out, counter, credit, fct_req, credit_error,
                     m_dv, m_dout, q.size(), m_credit, m_req, m_err);
         end
      end
      rx_valid = 0; fct_ack = 0;
      checks++;
      if (wr_cnt - start < 200) begin errors++; $display("FAIL stream_budget: got %0d writes want 200", wr_cnt - start); end
      n = 0;
      rd_en = 1;
      while (q.size() > 0 && n < 70) begin
         tick();
         n++;
         checks++;
         if (data_valid !== 1'b1 || data_out !== 9'(m_dout)) begin
            errors++; $display("FAIL drain%0d: got dv=%b d=%0h want 1 %0h", n, data_valid, data_out, m_dout);
         end
      end
      tick();
      rd_en = 0;
      checks++;
      if (data_valid !== 1'b0 || data_out !== 9'(m_dout) || f_empty !== 1'b1) begin
         errors++; $display("FAIL read_empty: got dv=%b d=%0h empty=%b want 0 %0h 1", data_valid, data_out, f_empty, m_dout);
      end
   endtask

`ifdef FIFO_RX_PKT_COUNT_EN
   task automatic test_pkt_count();
      int n = 0;
      fct_ack = 1;
      while (m_credit < 8 && n < 20) begin tick(); n++; end
      fct_ack = 0;
      rx_valid = 1; rx_data = 9'h100;
      repeat (3) tick();
      rx_valid = 0; rd_en = 1;
      tick();
      rd_en = 0;
      checks++;
      if (pkt_count !== 7'(markers()) || pkt_count !== 7'd2) begin
         errors++; $display("FAIL pkt_count: got %0d want 2 (model %0d)", pkt_count, markers());
      end
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_credit_init();
      test_fill();
      test_read8();
      test_simultaneous();
      test_link_drop();
      test_stream();
`ifdef FIFO_RX_PKT_COUNT_EN
      test_pkt_count();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
